// File: rtl/unary_reduce_pkg.sv
// Shared types and helpers for the pipelined unary reduction unit:
// opcode encoding, base-op/inversion/identity decode and tree geometry.
package unary_reduce_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    BASE_AND = 2'd0,
    BASE_OR  = 2'd1,
    BASE_XOR = 2'd2
  } base_e;

  // Reduction applied inside every tree level; reserved ops fall back to OR.
  function automatic base_e base_op(op_e op);
    case (op)
      OP_AND, OP_NAND: base_op = BASE_AND;
      OP_OR, OP_NOR:   base_op = BASE_OR;
      OP_XOR, OP_XNOR: base_op = BASE_XOR;
      default:         base_op = BASE_OR;
    endcase
  endfunction

  // Ops whose result is inverted in the last stage only.
  function automatic logic is_inv(op_e op);
    case (op)
      OP_NAND, OP_NOR, OP_XNOR: is_inv = 1'b1;
      default:                  is_inv = 1'b0;
    endcase
  endfunction

  function automatic logic is_rsv(op_e op);
    case (op)
      OP_RSV6, OP_RSV7: is_rsv = 1'b1;
      default:          is_rsv = 1'b0;
    endcase
  endfunction

  // Neutral padding bit for partial groups.
  function automatic logic identity(op_e op);
    case (op)
      OP_AND, OP_NAND: identity = 1'b1;
      default:         identity = 1'b0;
    endcase
  endfunction

  // Number of tree levels: smallest L with G**L >= N, never below 1.
  function automatic int stages(int n, int g);
    longint p;
    int     l;
    p = 64'd1;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (p < longint'(n)) begin
        p = p * longint'(g);
        l = l + 1;
      end else begin
        p = p;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  // Width of the data vector entering tree level s: ceil(N / G**s).
  function automatic int stage_w(int n, int g, int s);
    longint d;
    d = 64'd1;
    for (int i = 0; i < s; i++) begin
      d = d * longint'(g);
    end
    return int'((longint'(n) + d - 64'd1) / d);
  endfunction

endpackage

// File: rtl/pipelined_unary_reduce_if.sv
// Operand/result handshake bundle for pipelined_unary_reduce.
// master drives operands and consumes results; slave is the reducer.
interface pipelined_unary_reduce_if #(
  parameter int N = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic         c;
  logic         err;

  modport master (
    output in_valid, a, op, out_ready,
    input  in_ready, out_valid, c, err
  );

  modport slave (
    input  in_valid, a, op, out_ready,
    output in_ready, out_valid, c, err
  );
endinterface

// File: rtl/unary_reduce_stage.sv
// One registered level of the G-ary reduction tree. Each group of G input
// bits collapses to one bit with the base op; the partial top group is
// padded with the op's identity. A held slot frees up whenever downstream
// takes it, so accept and emit may happen in the same cycle.
module unary_reduce_stage
  import unary_reduce_pkg::*;
#(
  parameter int W_IN  = 8,
  parameter int G     = 4,
  parameter int W_OUT = (W_IN + G - 1) / G
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [W_IN-1:0]  in_data,
  input  op_e              in_op,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [W_OUT-1:0] out_data,
  output op_e              out_op
);

  localparam int W_PAD = W_OUT * G;

  logic             vld_q, vld_d;
  logic [W_OUT-1:0] data_q, data_d;
  op_e              op_q, op_d;
  logic [W_PAD-1:0] pad_s;
  logic [G-1:0]     grp_s;

  assign in_rdy   = ~vld_q | out_rdy;
  assign out_vld  = vld_q;
  assign out_data = data_q;
  assign out_op   = op_q;

  // Next-state: load a reduced group vector when the slot is free, else hold.
  always_comb begin
    pad_s            = {W_PAD{identity(in_op)}};
    pad_s[W_IN-1:0]  = in_data;
    grp_s            = {G{1'b0}};
    vld_d            = vld_q;
    data_d           = data_q;
    op_d             = op_q;
    if (in_rdy) begin
      vld_d = in_vld;
      if (in_vld) begin
        op_d = in_op;
        for (int i = 0; i < W_OUT; i++) begin
          grp_s = pad_s[i*G +: G];
          case (base_op(in_op))
            BASE_AND: data_d[i] = &grp_s;
            BASE_OR:  data_d[i] = |grp_s;
            BASE_XOR: data_d[i] = ^grp_s;
            default:  data_d[i] = 1'b0;
          endcase
        end
      end else begin
        op_d = op_q;
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Stage register; reset empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= {W_OUT{1'b0}};
      op_q   <= OP_AND;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      op_q   <= op_d;
    end
  end

endmodule

// File: rtl/pipelined_unary_reduce.sv
// Pipelined unary reducer: N-bit operand -> 1 bit per transaction with a
// per-transaction op, through L = max(1, ceil(log_G N)) registered tree
// levels with valid/ready flow control. The last level's output is
// inverted for NAND/NOR/XNOR; reserved ops yield c=0, err=1.
// Optional build macro UNARY_REDUCE_STATS_EN adds saturating counters
// stat_txn (output transfers) and stat_ones (transfers with c=1).
module pipelined_unary_reduce
  import unary_reduce_pkg::*;
#(
  parameter int N = 8,
  parameter int G = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipelined_unary_reduce_if.slave       bus
`ifdef UNARY_REDUCE_STATS_EN
  ,
  output logic [31:0]                   stat_txn,
  output logic [31:0]                   stat_ones
`endif
);

  localparam int L = stages(N, G);

  logic live_q, live_d;
  logic c_s, err_s;
  op_e  op_last_s;

  assign live_d = 1'b1;

  // Input side stays closed until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= live_d;
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_st
    localparam int WI = stage_w(N, G, s);
    localparam int WO = stage_w(N, G, s + 1);

    logic [WI-1:0] din;
    logic          vin;
    op_e           oin;
    logic          rin;
    logic [WO-1:0] dout;
    logic          vout;
    op_e           oout;
    logic          rout;

    if (s == 0) begin : g_head
      assign din = bus.a;
      assign vin = bus.in_valid & live_q;
      assign oin = op_e'(bus.op);
    end else begin : g_body
      assign din = g_st[s-1].dout;
      assign vin = g_st[s-1].vout;
      assign oin = g_st[s-1].oout;
    end

    if (s == L - 1) begin : g_tail
      assign rout = bus.out_ready;
    end else begin : g_link
      assign rout = g_st[s+1].rin;
    end

    unary_reduce_stage #(
      .W_IN  (WI),
      .G     (G),
      .W_OUT (WO)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (vin),
      .in_rdy   (rin),
      .in_data  (din),
      .in_op    (oin),
      .out_vld  (vout),
      .out_rdy  (rout),
      .out_data (dout),
      .out_op   (oout)
    );
  end

  assign op_last_s = g_st[L-1].oout;

  // Final inversion and reserved-op flagging from the last stage register.
  always_comb begin
    if (is_rsv(op_last_s)) begin
      c_s   = 1'b0;
      err_s = 1'b1;
    end else begin
      c_s   = g_st[L-1].dout[0] ^ is_inv(op_last_s);
      err_s = 1'b0;
    end
  end

  assign bus.in_ready  = live_q & g_st[0].rin;
  assign bus.out_valid = g_st[L-1].vout;
  assign bus.c         = c_s;
  assign bus.err       = err_s;

`ifdef UNARY_REDUCE_STATS_EN
  logic [31:0] txn_q, txn_d;
  logic [31:0] ones_q, ones_d;
  logic        xfer_s;

  assign xfer_s = bus.out_valid & bus.out_ready;

  // Saturating increments on each output transfer.
  always_comb begin
    txn_d  = txn_q;
    ones_d = ones_q;
    if (xfer_s) begin
      if (txn_q != 32'hFFFF_FFFF) begin
        txn_d = txn_q + 32'd1;
      end else begin
        txn_d = txn_q;
      end
      if (c_s && (ones_q != 32'hFFFF_FFFF)) begin
        ones_d = ones_q + 32'd1;
      end else begin
        ones_d = ones_q;
      end
    end else begin
      txn_d  = txn_q;
      ones_d = ones_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q  <= 32'd0;
      ones_q <= 32'd0;
    end else begin
      txn_q  <= txn_d;
      ones_q <= ones_d;
    end
  end

  assign stat_txn  = txn_q;
  assign stat_ones = ones_q;
`endif

endmodule

// File: tb/tb_pipelined_unary_reduce.sv
// Self-checking bench for pipelined_unary_reduce: an N=8/G=4 instance under
// directed and random traffic against a population-count reference model,
// plus an N=5/G=2 instance for partial-group padding.
module tb_pipelined_unary_reduce;

  localparam int L8 = 2;  // ceil(log2(8)/log2(4))
  localparam int L5 = 3;  // ceil(log2(5)/log2(2))

  typedef struct {
    logic c;
    logic err;
    int   t;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  logic lat_chk;
  exp_t exp_q[$];
  int   txn8;
  int   ones8;
  logic held;
  logic [1:0] held_v;

  pipelined_unary_reduce_if #(.N(8)) b8 ();
  pipelined_unary_reduce_if #(.N(5)) b5 ();

`ifdef UNARY_REDUCE_STATS_EN
  logic [31:0] stat_txn8, stat_ones8, stat_txn5, stat_ones5;
`endif

  pipelined_unary_reduce #(.N(8), .G(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
`ifdef UNARY_REDUCE_STATS_EN
    ,
    .stat_txn  (stat_txn8),
    .stat_ones (stat_ones8)
`endif
  );

  pipelined_unary_reduce #(.N(5), .G(2)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b5)
`ifdef UNARY_REDUCE_STATS_EN
    ,
    .stat_txn  (stat_txn5),
    .stat_ones (stat_ones5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: result from the count of ones among the low n bits.
  function automatic logic [1:0] ref_model(input logic [7:0] a, input int n, input int op);
    int  ones;
    logic all1, any1, odd;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(a[i]);
    all1 = (ones == n);
    any1 = (ones > 0);
    odd  = (ones % 2) == 1;
    case (op)
      0: return {1'b0, all1};
      1: return {1'b0, ~all1};
      2: return {1'b0, any1};
      3: return {1'b0, ~any1};
      4: return {1'b0, odd};
      5: return {1'b0, ~odd};
      default: return 2'b10;
    endcase
  endfunction

  // Scoreboard for the N=8 instance, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t  e;
    logic [1:0] r;
    if (!rst_n) begin
      exp_q.delete();
      txn8  = 0;
      ones8 = 0;
      held  = 1'b0;
    end else begin
      if (b8.out_valid && b8.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("c", {31'd0, b8.c}, {31'd0, e.c});
          check_eq("err", {31'd0, b8.err}, {31'd0, e.err});
          if (lat_chk) check_eq("latency", cyc - e.t, L8);
          txn8++;
          if (b8.c) ones8++;
        end
      end
      if (b8.out_valid && !b8.out_ready) begin
        if (held) check_eq("held_out", {30'd0, b8.c, b8.err}, {30'd0, held_v});
        held   = 1'b1;
        held_v = {b8.c, b8.err};
      end else begin
        held = 1'b0;
      end
      if (b8.in_valid && b8.in_ready) begin
        r = ref_model(b8.a, 8, int'(b8.op));
        e.c = r[0];
        e.err = r[1];
        e.t = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [2:0] op, output int tries);
    logic acc;
    tries = 0;
    acc = 1'b0;
    b8.in_valid = 1'b1;
    b8.a = a;
    b8.op = op;
    while (!acc && tries < 64) begin
      @(negedge clk);
      acc = b8.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) check_eq("accept_timeout", 32'd0, 32'd1);
    b8.in_valid = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain", exp_q.size(), 32'd0);
  endtask

  task automatic run5(input logic [4:0] a, input logic [2:0] op, input logic exp_c);
    int   n;
    logic acc;
    b5.in_valid = 1'b1;
    b5.a = a;
    b5.op = op;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = b5.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    b5.in_valid = 1'b0;
    n = 0;
    while (!b5.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("n5_latency", n, L5 - 1);
    check_eq("n5_c", {31'd0, b5.c}, {31'd0, exp_c});
    check_eq("n5_err", {31'd0, b5.err}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    int acc;
    int ov;
    logic [7:0] va;
    logic [7:0] v07;
    logic [4:0] n5_a [8];
    logic [2:0] n5_op [8];
    logic       n5_c [8];

    n_cmp = 0; n_err = 0; cyc = 0; lat_chk = 1'b0;
    txn8 = 0; ones8 = 0; held = 1'b0; held_v = 2'b00;
    rst_n = 1'b0;
    b8.in_valid = 1'b0; b8.a = 8'h00; b8.op = 3'd0; b8.out_ready = 1'b1;
    b5.in_valid = 1'b0; b5.a = 5'h00; b5.op = 3'd0; b5.out_ready = 1'b1;

    // Reset state
    #1;
    check_eq("rst_out_valid", {31'd0, b8.out_valid}, 32'd0);
    check_eq("rst_c", {31'd0, b8.c}, 32'd0);
    check_eq("rst_err", {31'd0, b8.err}, 32'd0);
    check_eq("rst_in_ready", {31'd0, b8.in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("in_ready_after_rst", {31'd0, b8.in_ready}, 32'd1);

    // NOR directed with exact latency
    lat_chk = 1'b1;
    drive8(8'h00, 3'd3, tries);
    drain8();
    drive8(8'h10, 3'd3, tries);
    drain8();

    // Every op on 8'hFF, then XOR/AND on 8'h07
    for (int op = 0; op < 6; op++) drive8(8'hFF, op[2:0], tries);
    v07 = 8'h07;
    drive8(v07, 3'd4, tries);
    drive8(v07, 3'd0, tries);
    drain8();

    // 16 back-to-back random transactions, one accept per cycle
    for (int i = 0; i < 16; i++) begin
      va = 8'($urandom);
      drive8(va, 3'($urandom_range(0, 5)), tries);
      check_eq("b2b_ready", tries, 32'd1);
    end
    drain8();
    lat_chk = 1'b0;

    // Reset with two transactions in flight
    drive8(8'hFF, 3'd0, tries);
    drive8(8'h00, 3'd2, tries);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'd0, b8.out_valid}, 32'd0);
    check_eq("midrst_c", {31'd0, b8.c}, 32'd0);
    check_eq("midrst_err", {31'd0, b8.err}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_eq("release_in_ready_low", {31'd0, b8.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("release_in_ready_high", {31'd0, b8.in_ready}, 32'd1);
    ov = 0;
    repeat (6) begin
      @(negedge clk);
      if (b8.out_valid) ov++;
    end
    check_eq("stale_after_rst", ov, 32'd0);
    @(posedge clk);
    #1;

    // Output stall with continuous input
    b8.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      b8.in_valid = 1'b1;
      b8.a = 8'($urandom);
      b8.op = 3'($urandom_range(0, 5));
      @(negedge clk);
      if (b8.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    check_eq("stall_accepts_bounded", {31'd0, (acc >= 1 && acc <= L8 + 1)}, 32'd1);
    check_eq("stall_in_ready", {31'd0, b8.in_ready}, 32'd0);
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    drain8();

    // Random valid/ready traffic including reserved ops
    for (int i = 0; i < 80; i++) begin
      b8.in_valid = 1'($urandom);
      b8.a = 8'($urandom);
      b8.op = 3'($urandom_range(0, 7));
      b8.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    drain8();

    // Reserved op
    drive8(8'hA5, 3'd6, tries);
    drive8(8'h3C, 3'd7, tries);
    drain8();

    // N=5, G=2: partial groups padded with the op identity
    n5_a  = '{5'h1F, 5'h0F, 5'h1F, 5'h10, 5'h00, 5'h10, 5'h03, 5'h1F};
    n5_op = '{3'd0,  3'd0,  3'd1,  3'd2,  3'd3,  3'd4,  3'd5,  3'd4};
    n5_c  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
    for (int i = 0; i < 8; i++) run5(n5_a[i], n5_op[i], n5_c[i]);

`ifdef UNARY_REDUCE_STATS_EN
    check_eq("stat_txn", stat_txn8, txn8);
    check_eq("stat_ones", stat_ones8, ones8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
